// File: rtl/uart_loader_pkg.sv
// ============================================================================
// Module      : uart_loader_pkg
// Description : Shared state encodings and byte field positions for the
//               UART pixel loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_loader_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_PIX0 = 2'd1,
        E_PIX1 = 2'd2
    } emit_state_t;

    localparam int SYNC_BIT = 7;
    localparam int PIX_W    = 3;
    localparam int PIX0_LSB = 0;
    localparam int PIX1_LSB = 3;

    function automatic logic is_sync(input logic [7:0] b);
        return b[SYNC_BIT];
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 2-flop synchronizer plus UART receiver (8N1, or 8E1 when
//               UART_LOADER_PARITY_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int               CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       r_sync;
    logic             r_rx_prev;
    logic             w_rx;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             w_tick;
    logic             w_par_ok;

    assign w_rx    = r_sync[1];
    assign w_tick  = (r_cnt == C_FULL);
    assign rx_byte = r_shift;

`ifdef UART_LOADER_PARITY_EN
    logic r_par_bad;
    assign w_par_ok = ~r_par_bad;
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
            r_par_bad  <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
            err        <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (r_rx_prev && !w_rx)
                        r_state <= RX_START;
                end
                RX_START: begin
                    // A line that is high again at mid-bit was only a glitch
                    if (r_cnt == C_HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
                            r_state <= RX_PARITY;
`else
                            r_state <= RX_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_LOADER_PARITY_EN
                RX_PARITY: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        r_par_bad <= ^{r_shift, w_rx};
                        r_state   <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (w_rx && w_par_ok)
                            byte_valid <= 1'b1;
                        else
                            err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_pixel_loader.sv
// ============================================================================
// Module      : uart_pixel_loader
// Description : UART byte stream to (hpos, vpos, RGB) pixel write requests,
//               two 3-bit pixels per byte. Optional 8E1 framing via
//               UART_LOADER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_pixel_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_HZ       = 25_000_000,
    parameter int BAUD         = 115_200,
    parameter int X_WIRE_WIDTH = 10,
    parameter int Y_WIRE_WIDTH = 10,
    parameter int GRID_H       = 80,
    parameter int GRID_V       = 60,
    parameter int CELL         = 8
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    input  logic                    push,
    output logic                    pixready,
    output logic [X_WIRE_WIDTH-1:0] hpos,
    output logic [Y_WIRE_WIDTH-1:0] vpos,
    output logic [2:0]              RGB,
    output logic                    frame_done,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int            CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int            CX_W         = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int            CY_W         = (GRID_V > 1) ? $clog2(GRID_V) : 1;
    localparam logic [CX_W-1:0] C_CX_LAST  = CX_W'(GRID_H - 1);
    localparam logic [CY_W-1:0] C_CY_LAST  = CY_W'(GRID_V - 1);

    logic [7:0]       w_rx_byte;
    logic             w_byte_valid;
    logic             w_rx_err;

    emit_state_t      r_estate;
    logic             r_pend_valid;
    logic [7:0]       r_pend_byte;
    logic [PIX_W-1:0] r_pix1;
    logic [CX_W-1:0]  r_cx;
    logic [CY_W-1:0]  r_cy;

    logic             w_fire;
    logic             w_take;
    logic             w_load;
    logic [7:0]       w_src;
    logic             w_unused_bit6;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_byte    (w_rx_byte),
        .byte_valid (w_byte_valid),
        .err        (w_rx_err)
    );

    // The emitter takes a new byte when idle or on the final push of a byte;
    // the pending slot is always older than a byte arriving this cycle.
    assign w_fire        = pixready && push;
    assign w_take        = (r_estate == E_IDLE) || ((r_estate == E_PIX1) && w_fire);
    assign w_load        = w_take && (r_pend_valid || w_byte_valid);
    assign w_src         = r_pend_valid ? r_pend_byte : w_rx_byte;
    assign w_unused_bit6 = w_src[6];

    assign hpos = X_WIRE_WIDTH'(32'(r_cx) * CELL);
    assign vpos = Y_WIRE_WIDTH'(32'(r_cy) * CELL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_byte  <= '0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (w_rx_err)
                frame_err <= 1'b1;
            if (w_load && r_pend_valid) begin
                r_pend_valid <= w_byte_valid;
                r_pend_byte  <= w_rx_byte;
            end else if (w_byte_valid && !w_load) begin
                if (r_pend_valid) begin
                    overrun <= 1'b1;
                end else begin
                    r_pend_valid <= 1'b1;
                    r_pend_byte  <= w_rx_byte;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estate   <= E_IDLE;
            pixready   <= 1'b0;
            RGB        <= '0;
            r_pix1     <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_fire) begin
                if (r_cx == C_CX_LAST) begin
                    r_cx <= '0;
                    if (r_cy == C_CY_LAST) begin
                        r_cy       <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        r_cy <= r_cy + 1'b1;
                    end
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end
            // A SYNC byte is applied after any push in the same cycle
            if (w_load && is_sync(w_src)) begin
                r_cx <= '0;
                r_cy <= '0;
            end
            case (r_estate)
                E_PIX0: begin
                    if (w_fire) begin
                        r_estate <= E_PIX1;
                        RGB      <= r_pix1;
                    end
                end
                default: begin
                    if (w_take) begin
                        if (w_load && !is_sync(w_src)) begin
                            r_estate <= E_PIX0;
                            pixready <= 1'b1;
                            RGB      <= w_src[PIX0_LSB +: PIX_W];
                            r_pix1   <= w_src[PIX1_LSB +: PIX_W];
                        end else begin
                            r_estate <= E_IDLE;
                            pixready <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
